// File: rtl/masked_gf16_inv_pipe_if.sv
// Bundle of the two-lane masked inverter: input shares, fresh randomness,
// and the returned shared inverses.
interface masked_gf16_inv_pipe_if #(
  parameter int unsigned RAND_W = 8
);
  logic              in_valid;
  logic [3:0]        xa0, xa1, xb0, xb1;
  logic [RAND_W-1:0] ra, rb;
  logic              out_valid;
  logic [3:0]        ia0, ia1, ib0, ib1;

  modport master (
    output in_valid, xa0, xa1, xb0, xb1, ra, rb,
    input  out_valid, ia0, ia1, ib0, ib1
  );

  modport slave (
    input  in_valid, xa0, xa1, xb0, xb1, ra, rb,
    output out_valid, ia0, ia1, ib0, ib1
  );
endinterface

// File: rtl/masked_gf16_inv_pipe.sv
// First-order masked GF(2^4) inverter (x^14) for two S-box lanes, built from
// two DOM-indep multipliers in a 2-stage pipeline with valid tracking.
module masked_gf16_inv_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] x0,
  input  logic [3:0] x1,
  input  logic [7:0] r,
  output logic [3:0] i0,
  output logic [3:0] i1
);
  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] acc;
    logic [3:0] t;
    acc = '0;
    t   = a;
    for (int unsigned k = 0; k < 4; k++) begin
      if (b[k]) acc = acc ^ t;
      t = {t[2:0], 1'b0} ^ (t[3] ? 4'h3 : 4'h0);
    end
    return acc;
  endfunction

  logic [3:0] s0, s1, q0, q1, e0, e1;
  logic [3:0] inner0_q, inner1_q, cross01_q, cross10_q;
  logic [3:0] x8_0_q, x8_1_q, r2_q;
  logic [3:0] p0, p1;

  // Squaring is linear, so each share is raised independently.
  always_comb begin
    s0 = gf_mul(x0, x0);
    s1 = gf_mul(x1, x1);
    q0 = gf_mul(s0, s0);
    q1 = gf_mul(s1, s1);
    e0 = gf_mul(q0, q0);
    e1 = gf_mul(q1, q1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inner0_q  <= '0;
      inner1_q  <= '0;
      cross01_q <= '0;
      cross10_q <= '0;
      x8_0_q    <= '0;
      x8_1_q    <= '0;
      r2_q      <= '0;
    end else begin
      inner0_q  <= gf_mul(s0, q0);
      inner1_q  <= gf_mul(s1, q1);
      cross01_q <= gf_mul(s0, q1) ^ r[3:0];
      cross10_q <= gf_mul(s1, q0) ^ r[3:0];
      x8_0_q    <= e0;
      x8_1_q    <= e1;
      r2_q      <= r[7:4];
    end
  end

  // Stage-2 randomness travels with its operation, so it is delayed one cycle.
  assign p0 = inner0_q ^ cross01_q;
  assign p1 = inner1_q ^ cross10_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      i0 <= '0;
      i1 <= '0;
    end else begin
      i0 <= gf_mul(p0, x8_0_q) ^ (gf_mul(p0, x8_1_q) ^ r2_q);
      i1 <= gf_mul(p1, x8_1_q) ^ (gf_mul(p1, x8_0_q) ^ r2_q);
    end
  end
endmodule

module masked_gf16_inv_pipe #(
  parameter int unsigned RAND_W = 8
) (
  input logic                    clk,
  input logic                    rst,
  masked_gf16_inv_pipe_if.slave  bus
);
  logic [1:0] v;

  always_ff @(posedge clk) begin
    if (rst) v <= '0;
    else     v <= {v[0], bus.in_valid};
  end

  assign bus.out_valid = v[1];

  masked_gf16_inv_lane u_lane_a (
    .clk (clk),
    .rst (rst),
    .x0  (bus.xa0),
    .x1  (bus.xa1),
    .r   (bus.ra[7:0]),
    .i0  (bus.ia0),
    .i1  (bus.ia1)
  );

  masked_gf16_inv_lane u_lane_b (
    .clk (clk),
    .rst (rst),
    .x0  (bus.xb0),
    .x1  (bus.xb1),
    .r   (bus.rb[7:0]),
    .i0  (bus.ib0),
    .i1  (bus.ib1)
  );
endmodule

// File: tb/tb_masked_gf16_inv_pipe.sv
// Randomized bench for the masked GF(2^4) inverter, checked against a
// field-inverse table and a two-deep latency line.
module tb_masked_gf16_inv_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  masked_gf16_inv_pipe_if #(.RAND_W(8)) bus ();

  masked_gf16_inv_pipe #(.RAND_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [3:0] inv_tbl [16] = '{4'h0, 4'h1, 4'h9, 4'hE, 4'hD, 4'hB, 4'h7, 4'h6,
                               4'hF, 4'h2, 4'hC, 4'h5, 4'hA, 4'h4, 4'h3, 4'h8};

  int n_vec = 0;
  int n_bad = 0;

  // expected-result delay line: [0] = accepted last edge, [1] = due at output
  bit         mv [2];
  logic [3:0] ma [2];
  logic [3:0] mb [2];

  bit capture_en = 0;
  bit seen_a0 [16];

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic v,
                     input logic [3:0] a0, input logic [3:0] a1,
                     input logic [3:0] b0, input logic [3:0] b1,
                     input logic [7:0] rA, input logic [7:0] rB);
    rst          = r;
    bus.in_valid = v;
    bus.xa0 = a0; bus.xa1 = a1;
    bus.xb0 = b0; bus.xb1 = b1;
    bus.ra  = rA; bus.rb  = rB;
    @(posedge clk);
    #1;
    if (r) begin
      mv[0] = 0; mv[1] = 0;
      ma[0] = '0; ma[1] = '0; mb[0] = '0; mb[1] = '0;
    end else begin
      mv[1] = mv[0]; ma[1] = ma[0]; mb[1] = mb[0];
      mv[0] = v;
      ma[0] = inv_tbl[a0 ^ a1];
      mb[0] = inv_tbl[b0 ^ b1];
    end
    chk("out_valid", {7'd0, bus.out_valid}, {7'd0, mv[1]});
    if (r) begin
      chk("rst_ia0", {4'd0, bus.ia0}, 8'h00);
      chk("rst_ia1", {4'd0, bus.ia1}, 8'h00);
      chk("rst_ib0", {4'd0, bus.ib0}, 8'h00);
      chk("rst_ib1", {4'd0, bus.ib1}, 8'h00);
    end else if (mv[1]) begin
      chk("inv_a", {4'd0, bus.ia0 ^ bus.ia1}, {4'd0, ma[1]});
      chk("inv_b", {4'd0, bus.ib0 ^ bus.ib1}, {4'd0, mb[1]});
      if (capture_en) seen_a0[bus.ia0] = 1;
    end
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00);
  endtask

  task automatic op(input logic [3:0] xa, input logic [3:0] xb);
    logic [3:0] sa, sb;
    sa = 4'($urandom);
    sb = 4'($urandom);
    cyc(1'b0, 1'b1, sa, sa ^ xa, sb, sb ^ xb, 8'($urandom), 8'($urandom));
  endtask

  initial begin
    int distinct;
    for (int i = 0; i < 2; i++) begin mv[i] = 0; ma[i] = '0; mb[i] = '0; end
    for (int i = 0; i < 16; i++) seen_a0[i] = 0;

    // reset held with live-looking input traffic
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b1, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
          8'($urandom), 8'($urandom));
    for (int i = 0; i < 2; i++) begin
      idle();
      chk("post_rst_ia0", {4'd0, bus.ia0}, 8'h00);
      chk("post_rst_ia1", {4'd0, bus.ia1}, 8'h00);
      chk("post_rst_ib0", {4'd0, bus.ib0}, 8'h00);
      chk("post_rst_ib1", {4'd0, bus.ib1}, 8'h00);
    end

    // directed single operation
    cyc(1'b0, 1'b1, 4'h5, 4'h7, 4'hA, 4'h0, 8'h3C, 8'hA5);
    idle();
    chk("single_a", {4'd0, bus.ia0 ^ bus.ia1}, 8'h09);
    chk("single_b", {4'd0, bus.ib0 ^ bus.ib1}, 8'h0C);
    idle();
    idle();

    // zero and one
    cyc(1'b0, 1'b1, 4'hF, 4'hF, 4'h6, 4'h7, 8'($urandom), 8'($urandom));
    idle();
    chk("zero_a", {4'd0, bus.ia0 ^ bus.ia1}, 8'h00);
    chk("one_b",  {4'd0, bus.ib0 ^ bus.ib1}, 8'h01);
    idle();

    // all 256 (xa, xb) pairs back to back
    for (int p = 0; p < 256; p++) begin
      logic [7:0] pv;
      pv = 8'(p);
      op(pv[7:4], pv[3:0]);
    end
    idle();
    idle();

    // fixed xa=3 and fixed split, sweep ra
    capture_en = 1;
    for (int k = 0; k < 256; k++)
      cyc(1'b0, 1'b1, 4'h1, 4'h2, 4'($urandom), 4'($urandom), 8'(k), 8'($urandom));
    idle();
    idle();
    capture_en = 0;
    distinct = 0;
    for (int i = 0; i < 16; i++) if (seen_a0[i]) distinct++;
    chk("mask_share_varies", {7'd0, distinct > 1}, 8'h01);

    // reset mid-flight, then a fresh op
    op(4'h7, 4'hB);
    cyc(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00);
    idle();
    op(4'h4, 4'h9);
    idle();
    chk("after_rst_a", {4'd0, bus.ia0 ^ bus.ia1}, 8'h0D);
    chk("after_rst_b", {4'd0, bus.ib0 ^ bus.ib1}, 8'h02);
    idle();
    idle();

    // random streaming with bubbles and occasional reset
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 29) == 0)
        cyc(1'b1, 1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
            8'($urandom), 8'($urandom));
      else if ($urandom_range(0, 3) == 0)
        cyc(1'b0, 1'b0, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
            8'($urandom), 8'($urandom));
      else
        op(4'($urandom), 4'($urandom));
    end
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
